// File: rtl/lane_pkg.sv
// Shared constants and encodings for the Hough lane-detection candidate queue path.
package lane_pkg;

    localparam int MSB_R_DEF   = 11;
    localparam int MSB_PHI_DEF = 7;
    localparam int DEPTH_DEF   = 8;
    localparam int MSB_OCC_DEF = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Requester index doubles as the bit position in the arbiter req/grant vectors.
    typedef enum logic [1:0] {
        REQ_A = 2'd0,
        REQ_B = 2'd1,
        REQ_P = 2'd2
    } req_e;

endpackage

// File: rtl/queue_sched_if.sv
// Producer, consumer and queue-port signals of the candidate-queue scheduler.
interface queue_sched_if
    import lane_pkg::*;
#(
    parameter int MSB_R   = MSB_R_DEF,
    parameter int MSB_PHI = MSB_PHI_DEF
);
    logic               a_valid;
    logic [MSB_R:0]     a_r;
    logic [MSB_PHI:0]   a_phi;
    logic               a_ready;
    logic               b_valid;
    logic [MSB_R:0]     b_r;
    logic [MSB_PHI:0]   b_phi;
    logic               b_ready;
    logic               out_valid;
    logic [MSB_R:0]     out_r;
    logic [MSB_PHI:0]   out_phi;
    logic               out_ready;
    logic               q_en;
    logic               q_rw;
    logic [MSB_R:0]     q_r_in;
    logic [MSB_PHI:0]   q_phi_in;
    logic [MSB_R:0]     q_r_out;
    logic [MSB_PHI:0]   q_phi_out;
    logic               q_empty;

    modport master (
        input  a_valid, a_r, a_phi, b_valid, b_r, b_phi, out_ready,
        input  q_r_out, q_phi_out, q_empty,
        output a_ready, b_ready, out_valid, out_r, out_phi,
        output q_en, q_rw, q_r_in, q_phi_in
    );

    modport slave (
        output a_valid, a_r, a_phi, b_valid, b_r, b_phi, out_ready,
        output q_r_out, q_phi_out, q_empty,
        input  a_ready, b_ready, out_valid, out_r, out_phi,
        input  q_en, q_rw, q_r_in, q_phi_in
    );

endinterface

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter; priority starts just after the last granted requester.
module rr_arb3
    import lane_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    req_e rr_q;
    req_e rr_d;

    always_comb begin
        grant = '0;
        case (rr_q)
            REQ_P: begin
                if      (req[0]) grant[0] = 1'b1;
                else if (req[1]) grant[1] = 1'b1;
                else if (req[2]) grant[2] = 1'b1;
            end
            REQ_A: begin
                if      (req[1]) grant[1] = 1'b1;
                else if (req[2]) grant[2] = 1'b1;
                else if (req[0]) grant[0] = 1'b1;
            end
            default: begin
                if      (req[2]) grant[2] = 1'b1;
                else if (req[0]) grant[0] = 1'b1;
                else if (req[1]) grant[1] = 1'b1;
            end
        endcase
    end

    always_comb begin
        rr_d = rr_q;
        if (clear)         rr_d = REQ_P;
        else if (grant[0]) rr_d = REQ_A;
        else if (grant[1]) rr_d = REQ_B;
        else if (grant[2]) rr_d = REQ_P;
    end

    always_ff @(posedge clk) begin
        if (reset) rr_q <= REQ_P;
        else       rr_q <= rr_d;
    end

endmodule

// File: rtl/queue_sched.sv
// Shares the single push/pop port of the 8-deep (r, phi) queue between two
// producers and the lane selector, with occupancy tracking and frame flush.
module queue_sched
    import lane_pkg::*;
#(
    parameter int MSB_R   = MSB_R_DEF,
    parameter int MSB_PHI = MSB_PHI_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MSB_OCC = MSB_OCC_DEF
)(
    input  logic               clk,
    input  logic               reset,
    queue_sched_if.master      bus,
    input  logic               flush,
    output logic               flush_done,
    output logic [MSB_OCC:0]   occ,
    output logic               err
);

    localparam logic [MSB_OCC:0] OCC_FULL = (MSB_OCC + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [MSB_OCC:0]   occ_q, occ_d;
    logic               out_valid_q, out_valid_d;
    logic [MSB_R:0]     out_r_q, out_r_d;
    logic [MSB_PHI:0]   out_phi_q, out_phi_d;
    logic               err_q, err_d;

    logic [2:0] req;
    logic [2:0] grant;
    logic       occ_full, occ_empty;
    logic       push, pop, flush_pop;

    assign occ_full  = (occ_q == OCC_FULL);
    assign occ_empty = (occ_q == '0);

    // Requests are only raised in RUN and never during reset, which also keeps
    // the grant-derived readies and q_en low while reset is asserted.
    always_comb begin
        req = '0;
        if (!reset && state_q == RUN) begin
            req[REQ_A] = bus.a_valid & ~occ_full;
            req[REQ_B] = bus.b_valid & ~occ_full;
            req[REQ_P] = ~occ_empty & (~out_valid_q | bus.out_ready);
        end
    end

    rr_arb3 u_arb (
        .clk   (clk),
        .reset (reset),
        .clear (flush_done),
        .req   (req),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_phi_d   = out_phi_q;
        err_d       = err_q | (bus.q_empty != occ_empty);

        flush_pop  = !reset && state_q == FLUSH && !occ_empty;
        flush_done = !reset && state_q == FLUSH && occ_empty;
        push       = grant[REQ_A] | grant[REQ_B];
        pop        = grant[REQ_P] | flush_pop;

        bus.a_ready  = grant[REQ_A];
        bus.b_ready  = grant[REQ_B];
        bus.q_en     = push | pop;
        bus.q_rw     = push;
        bus.q_r_in   = '0;
        bus.q_phi_in = '0;
        if (grant[REQ_A]) begin
            bus.q_r_in   = bus.a_r;
            bus.q_phi_in = bus.a_phi;
        end else if (grant[REQ_B]) begin
            bus.q_r_in   = bus.b_r;
            bus.q_phi_in = bus.b_phi;
        end

        if (push)     occ_d = occ_q + 1'b1;
        else if (pop) occ_d = occ_q - 1'b1;

        // A pop refills the output register even while the current entry is taken.
        if (grant[REQ_P]) begin
            out_valid_d = 1'b1;
            out_r_d     = bus.q_r_out;
            out_phi_d   = bus.q_phi_out;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d     = FLUSH;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                if (occ_empty) state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_phi_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_phi_q   <= out_phi_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_phi   = out_phi_q;
    assign occ           = occ_q;
    assign err           = err_q;

endmodule

// File: tb/tb_queue_sched.sv
// Randomized scoreboard bench for queue_sched against a queue-based reference model.
module tb_queue_sched;
    import lane_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  flush;
    logic                  flush_done;
    logic [MSB_OCC_DEF:0]  occ;
    logic                  err;

    queue_sched_if bus ();

    queue_sched dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .occ        (occ),
        .err        (err)
    );

    typedef struct {
        bit                     rst;
        bit                     ar;
        bit                     br;
        bit                     qen;
        bit                     qrw;
        logic [MSB_R_DEF:0]     qr;
        logic [MSB_PHI_DEF:0]   qp;
        logic [MSB_OCC_DEF:0]   occ;
        bit                     ov;
        logic [MSB_R_DEF:0]     orr;
        logic [MSB_PHI_DEF:0]   op;
        bit                     fd;
        bit                     er;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Environment: a behavioural stand-in for the physical lane queue.
    logic [MSB_R_DEF:0]   mem_r[$];
    logic [MSB_PHI_DEF:0] mem_p[$];
    bit                   pend_en = 1'b0;
    bit                   pend_rw = 1'b0;
    logic [MSB_R_DEF:0]   pend_r;
    logic [MSB_PHI_DEF:0] pend_p;

    always @(negedge clk) begin
        pend_en = bus.q_en && !reset;
        pend_rw = bus.q_rw;
        pend_r  = bus.q_r_in;
        pend_p  = bus.q_phi_in;
    end

    always @(posedge clk) begin
        if (reset) begin
            mem_r.delete();
            mem_p.delete();
        end else if (pend_en) begin
            if (pend_rw) begin
                mem_r.push_back(pend_r);
                mem_p.push_back(pend_p);
            end else if (mem_r.size() > 0) begin
                void'(mem_r.pop_front());
                void'(mem_p.pop_front());
            end
        end
    end

    // Reference model: queue contents, output register, flush mode, last grant.
    logic [MSB_R_DEF:0]   m_r[$];
    logic [MSB_PHI_DEF:0] m_p[$];
    bit                   m_ov  = 1'b0;
    logic [MSB_R_DEF:0]   m_or  = '0;
    logic [MSB_PHI_DEF:0] m_op  = '0;
    bit                   m_fl  = 1'b0;
    int                   m_last = 2;
    bit                   m_err = 1'b0;

    task automatic cycle(input bit rst, input bit av, input bit bv, input bit ordy,
                         input bit fl, input bit fe,
                         input logic [MSB_R_DEF:0] ar, input logic [MSB_PHI_DEF:0] ap,
                         input logic [MSB_R_DEF:0] br, input logic [MSB_PHI_DEF:0] bp);
        exp_t e;
        int   cnt;
        int   g;
        bit   rq[3];
        @(posedge clk);
        #1;
        reset         = rst;
        flush         = fl;
        bus.a_valid   = av;
        bus.a_r       = ar;
        bus.a_phi     = ap;
        bus.b_valid   = bv;
        bus.b_r       = br;
        bus.b_phi     = bp;
        bus.out_ready = ordy;
        bus.q_r_out   = (mem_r.size() > 0) ? mem_r[0] : '0;
        bus.q_phi_out = (mem_p.size() > 0) ? mem_p[0] : '0;
        bus.q_empty   = fe || (mem_r.size() == 0);

        e     = '{default: 0};
        cnt   = m_r.size();
        e.rst = rst;
        e.occ = 4'(cnt);
        e.ov  = m_ov;
        e.orr = m_or;
        e.op  = m_op;
        e.er  = m_err;
        if (rst) begin
            m_r.delete();
            m_p.delete();
            m_ov = 0; m_or = '0; m_op = '0; m_fl = 0; m_last = 2; m_err = 0;
        end else begin
            if (!m_fl) begin
                rq[0] = av && cnt < DEPTH_DEF;
                rq[1] = bv && cnt < DEPTH_DEF;
                rq[2] = cnt > 0 && (!m_ov || ordy);
                g = -1;
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && rq[(m_last + 1 + k) % 3]) g = (m_last + 1 + k) % 3;
                end
                e.ar  = (g == 0);
                e.br  = (g == 1);
                e.qen = (g >= 0);
                e.qrw = (g == 0 || g == 1);
                if (g == 0) begin
                    e.qr = ar; e.qp = ap;
                    m_r.push_back(ar); m_p.push_back(ap);
                end else if (g == 1) begin
                    e.qr = br; e.qp = bp;
                    m_r.push_back(br); m_p.push_back(bp);
                end
                if (g == 2) begin
                    m_or = m_r.pop_front();
                    m_op = m_p.pop_front();
                    m_ov = 1;
                end else if (ordy) begin
                    m_ov = 0;
                end
                if (g >= 0) m_last = g;
                if (fl) begin
                    m_fl = 1;
                    m_ov = 0;
                end
            end else if (cnt > 0) begin
                e.qen = 1;
                void'(m_r.pop_front());
                void'(m_p.pop_front());
            end else begin
                e.fd   = 1;
                m_fl   = 0;
                m_last = 2;
            end
            if (bus.q_empty != (cnt == 0)) m_err = 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic rcycle(input bit rst, input bit av, input bit bv, input bit ordy,
                          input bit fl, input bit fe);
        cycle(rst, av, bv, ordy, fl, fe, 12'($urandom), 8'($urandom),
              12'($urandom), 8'($urandom));
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("a_ready", int'(bus.a_ready), int'(me.ar));
            chk("b_ready", int'(bus.b_ready), int'(me.br));
            chk("q_en",    int'(bus.q_en),    int'(me.qen));
            if (!me.rst) begin
                chk("q_rw",       int'(bus.q_rw),      int'(me.qrw));
                chk("q_r_in",     int'(bus.q_r_in),    int'(me.qr));
                chk("q_phi_in",   int'(bus.q_phi_in),  int'(me.qp));
                chk("occ",        int'(occ),           int'(me.occ));
                chk("out_valid",  int'(bus.out_valid), int'(me.ov));
                chk("out_r",      int'(bus.out_r),     int'(me.orr));
                chk("out_phi",    int'(bus.out_phi),   int'(me.op));
                chk("flush_done", int'(flush_done),    int'(me.fd));
                chk("err",        int'(err),           int'(me.er));
                if (bus.out_valid && bus.out_ready)
                    $display("deliver r=%03h phi=%02h occ=%0d t=%0t",
                             bus.out_r, bus.out_phi, occ, $time);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.a_valid = 1'b0; bus.a_r = '0; bus.a_phi = '0;
        bus.b_valid = 1'b0; bus.b_r = '0; bus.b_phi = '0;
        bus.out_ready = 1'b0; bus.q_r_out = '0; bus.q_phi_out = '0; bus.q_empty = 1'b1;

        repeat (2) rcycle(1, 0, 0, 0, 0, 0);
        // Single entry from A flows straight through to the consumer.
        cycle(0, 1, 0, 1, 0, 0, 12'h123, 8'h45, 12'h000, 8'h00);
        repeat (4) rcycle(0, 0, 0, 1, 0, 0);
        // Both producers, consumer stalled: alternate pushes until full.
        repeat (12) rcycle(0, 1, 1, 0, 0, 0);
        // Consumer draining: A, B, P rotation.
        repeat (20) rcycle(0, 1, 1, 1, 0, 0);
        // Output hold under backpressure, then back-to-back refill.
        repeat (5) rcycle(0, 1, 1, 0, 0, 0);
        repeat (6) rcycle(0, 0, 0, 1, 0, 0);
        // Fill, then flush a full queue while producers keep offering.
        repeat (12) rcycle(0, 1, 1, 0, 0, 0);
        rcycle(0, 1, 1, 0, 1, 0);
        repeat (4) rcycle(0, 1, 1, 1, 1, 0);
        repeat (10) rcycle(0, 1, 1, 1, 0, 0);
        // Randomized traffic with occasional flushes.
        repeat (400) rcycle(0, 1'($urandom), 1'($urandom), ($urandom % 4) != 0,
                            ($urandom % 40) == 0, 0);
        // Occupancy / empty-flag mismatch sets a sticky error.
        rcycle(1, 0, 0, 0, 0, 0);
        repeat (4) rcycle(0, 1, 0, 0, 0, 0);
        rcycle(0, 0, 0, 0, 0, 1);
        repeat (6) rcycle(0, 0, 0, 1, 0, 0);
        // Reset in the middle of a flush.
        rcycle(1, 0, 0, 0, 0, 0);
        repeat (10) rcycle(0, 1, 1, 0, 0, 0);
        rcycle(0, 0, 0, 0, 1, 0);
        repeat (3) rcycle(0, 1, 1, 1, 0, 0);
        rcycle(1, 1, 1, 1, 0, 0);
        repeat (8) rcycle(0, 1, 1, 1, 0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
